// File: rtl/store_buffer.sv
// In-order store buffer between commit and data memory: drains one store per
// cycle into the memory write port and forwards the youngest matching store to loads.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic                    drain_hold,
  input  logic                    ld_valid,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    ld_fwd,
  output logic [ADDR_WIDTH-1:0]   mem_read_addr,
  output logic                    mem_read_enable,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_write_enable,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  enq;
  logic                  drain;
  logic [PTR_W-1:0]      idx;

  // Store handshake: a store transfers on any cycle where st_valid && st_ready;
  // st_ready depends only on reset and occupancy, never on st_valid or draining.
  always_comb begin
    st_ready         = !reset && (count_q < CNT_W'(DEPTH));
    enq              = st_valid && st_ready;
    mem_write_enable = !reset && (count_q != '0) && !drain_hold;
    drain            = mem_write_enable;
    mem_write_addr   = addr_q[head_q];
    mem_write_data   = data_q[head_q];

    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;

    if (enq) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (drain) head_d = head_q + PTR_W'(1);

    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last hit wins; the draining head entry is
  // still counted, while this cycle's enqueue is not yet in count_q.
  always_comb begin
    ld_fwd  = 1'b0;
    ld_data = mem_read_data;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (ld_valid && (CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
        ld_fwd  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

  assign mem_read_addr   = ld_addr;
  assign mem_read_enable = ld_valid;
  assign count           = count_q;
  assign empty           = (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads are not reset; occupancy comes from count_q alone.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule
